// File: rtl/seq_tx_1110.sv
// Serial MSB-first transmitter with idle gap and a self-monitor that flags each transmitted 1110.
// Define SEQ_TX_PARITY_EN to append an even-parity bit (PAR state) after the data bits.
module seq_tx_1110 #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             load_ready,
    output logic             busy,
    output logic             seq_out,
    output logic             done,
    output logic             pattern_sent
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 32'sd1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [GW-1:0] GAP_LAST = (GAP > 32'sd0) ? GW'(GAP - 1) : GW'(0);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic [GW-1:0]    gap_q;
    logic [3:0]       hist_q;
    logic             done_q, done_d;
    logic             accept_s;
    logic             frame_end_s;
    state_e           after_data_s;

`ifdef SEQ_TX_PARITY_EN
    logic par_q;

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    assign accept_s    = load_valid && (state_q == ST_IDLE);
    assign frame_end_s = (state_q == ST_SHIFT) && (cnt_q == '0);

    // Where the FSM goes once the last data bit has been shifted out
    always_comb begin
        after_data_s = ST_IDLE;
`ifdef SEQ_TX_PARITY_EN
        after_data_s = ST_PAR;
`else
        if (GAP > 32'sd0) begin
            after_data_s = ST_GAP;
        end else begin
            after_data_s = ST_IDLE;
        end
`endif
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (frame_end_s) begin
                    state_d = after_data_s;
`ifndef SEQ_TX_PARITY_EN
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = ST_SHIFT;
                end
            end
`ifdef SEQ_TX_PARITY_EN
            ST_PAR: begin
                done_d = 1'b1;
                if (GAP > 32'sd0) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: shift register, counters, done flag and transmitted-bit history
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            hist_q  <= 4'b0000;
            done_q  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            hist_q <= {hist_q[2:0], seq_out};
            done_q <= done_d;
            // gap_q is preloaded while outside GAP so entry sees the full count
            if (state_q == ST_GAP) begin
                gap_q <= gap_q - GAP_ONE;
            end else begin
                gap_q <= GAP_LAST;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        shreg_q <= data_in;
                        cnt_q   <= CNT_LAST;
`ifdef SEQ_TX_PARITY_EN
                        par_q   <= even_parity(data_in);
`endif
                    end else begin
                        shreg_q <= shreg_q;
                        cnt_q   <= cnt_q;
                    end
                end
                ST_SHIFT: begin
                    shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_q   <= cnt_q - CNT_ONE;
                end
                default: begin
                    shreg_q <= shreg_q;
                    cnt_q   <= cnt_q;
                end
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        load_ready   = (state_q == ST_IDLE);
        busy         = (state_q != ST_IDLE);
        done         = done_q;
        pattern_sent = (hist_q == 4'b1110);
        case (state_q)
            ST_SHIFT: seq_out = shreg_q[WIDTH-1];
`ifdef SEQ_TX_PARITY_EN
            ST_PAR:   seq_out = par_q;
`endif
            default:  seq_out = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_seq_tx_1110.sv
// Self-checking bench for seq_tx_1110: directed test-plan sequences followed by random traffic,
// all compared against a queue-based model of the transmitted stream.
module tb_seq_tx_1110;

    localparam int WIDTH = 8;
    localparam int GAP   = 2;
`ifdef SEQ_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             load_valid;
    logic [WIDTH-1:0] data_in;
    logic             load_ready;
    logic             busy;
    logic             seq_out;
    logic             done;
    logic             pattern_sent;

    seq_tx_1110 #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .data_in      (data_in),
        .load_ready   (load_ready),
        .busy         (busy),
        .seq_out      (seq_out),
        .done         (done),
        .pattern_sent (pattern_sent)
    );

    always #5 clock = ~clock;

    // Model: q holds every bit still to appear on the line (frame bits then gap zeros);
    // the block is ready exactly when q is empty.
    bit   q[$];
    int   frame_left = 0;
    int   hist       = 0;
    logic exp_done   = 1'b0;
    int   n_vec      = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    bit   chk_en     = 1'b0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        bit   cur_ready;
        logic cur_bit;
        cur_ready = (q.size() == 0);
        cur_bit   = cur_ready ? 1'b0 : q[0];
        if (chk_en) begin
            check1("seq_out",      seq_out,      cur_bit);
            check1("load_ready",   load_ready,   cur_ready);
            check1("busy",         busy,         !cur_ready);
            check1("done",         done,         exp_done);
            check1("pattern_sent", pattern_sent, hist == 14);
        end
        if (reset) begin
            q.delete();
            frame_left = 0;
            hist       = 0;
            exp_done   = 1'b0;
        end else begin
            hist     = (hist * 2 + int'(cur_bit)) % 16;
            exp_done = !cur_ready && (frame_left == 1);
            if (!cur_ready) begin
                void'(q.pop_front());
                if (frame_left > 0) frame_left--;
            end else if (load_valid) begin
                for (int i = WIDTH - 1; i >= 0; i--) q.push_back(data_in[i]);
                if (PAR_BITS == 1) q.push_back(^data_in);
                for (int g = 0; g < GAP; g++) q.push_back(1'b0);
                frame_left = WIDTH + PAR_BITS;
            end
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        data_in    = '0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        repeat (5) step();

        // 8'hE0: 1110 completes inside the frame
        load_valid = 1'b1; data_in = 8'hE0;
        step();
        load_valid = 1'b0;
        repeat (12) step();

        // 8'hFF held valid, data changes mid-frame; 1110 completes on first gap zero
        load_valid = 1'b1; data_in = 8'hFF;
        step();
        data_in = 8'h00;
        repeat (11) step();
        load_valid = 1'b0;
        repeat (12) step();

        // 8'h77 aborted by reset during cycle 4
        load_valid = 1'b1; data_in = 8'h77;
        step();
        load_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (6) step();

        // 8'h6E: pattern coincides with done
        load_valid = 1'b1; data_in = 8'h6E;
        step();
        load_valid = 1'b0;
        repeat (13) step();

        // Random traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 59) == 0);
            load_valid = ($urandom_range(0, 2) != 0);
            data_in    = WIDTH'($urandom);
            step();
        end
        reset      = 1'b0;
        load_valid = 1'b0;
        repeat (15) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
